// File: rtl/spi_reg_bank.sv
// spi_reg_bank: pipelined Wishbone slave register bank with a streaming-read FIFO.
// Map: 0x00 STREAM, 0x01 FILL, 0x02 CTRL, 0x03 STATUS (W1C), 0x04-0x07 SCRATCH.
// Optional feature macro: SPI_REG_BANK_ERR_EN -- unmapped accesses end with err_o
// instead of ack_o. DELAY is kept for interface compatibility only; the RTL uses
// zero-delay assignments.

module spi_reg_bank #(
    parameter int WIDTH  = 8,
    parameter int ABITS  = 7,
    parameter int FDEPTH = 16,
    parameter int DELAY  = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [ABITS-1:0] adr_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             ack_o,
    output logic             wat_o,
    output logic             rty_o,
    output logic             err_o,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic [WIDTH-1:0] ctrl_o,
    output logic [WIDTH-1:0] status_o
);

    localparam int AW = $clog2(FDEPTH);
    localparam int CW = AW + 1;

    localparam logic [ABITS-1:0] A_STREAM = ABITS'(0);
    localparam logic [ABITS-1:0] A_FILL   = ABITS'(1);
    localparam logic [ABITS-1:0] A_CTRL   = ABITS'(2);
    localparam logic [ABITS-1:0] A_STATUS = ABITS'(3);
    localparam logic [ABITS-1:0] A_SCR0   = ABITS'(4);
    localparam logic [ABITS-1:0] A_SCR1   = ABITS'(5);
    localparam logic [ABITS-1:0] A_SCR2   = ABITS'(6);
    localparam logic [ABITS-1:0] A_SCR3   = ABITS'(7);

    // Elaboration-time parameter sanity checks.
    if (WIDTH != 8) begin : g_bad_width
        $error("spi_reg_bank: WIDTH must be 8");
    end
    if (FDEPTH < 2 || FDEPTH > 128 || (FDEPTH & (FDEPTH - 1)) != 0) begin : g_bad_depth
        $error("spi_reg_bank: FDEPTH must be a power of two in 2..128");
    end
    if (DELAY < 0) begin : g_bad_delay
        $error("spi_reg_bank: DELAY must be non-negative");
    end

    logic [6:0]            ctrl_q, ctrl_d;
    logic [3:0][WIDTH-1:0] scratch_q, scratch_d;
    logic                  ovf_q, ovf_d;
    logic                  udr_q, udr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic [WIDTH-1:0]      dat_q, dat_d;
    logic                  wat_q, wat_d;
    logic                  rdy_en_q, rdy_en_d;
    logic [WIDTH-1:0]      mem_q [FDEPTH];

    logic acc, rd_acc, wr_acc, empty, full, push, pop, flush;

    assign acc    = cyc_i && stb_i && !wat_q;
    assign rd_acc = acc && !we_i;
    assign wr_acc = acc && we_i;
    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CW'(FDEPTH));
    assign flush  = wr_acc && (adr_i == A_CTRL) && dat_i[7];
    assign pop    = rd_acc && (adr_i == A_STREAM) && !empty;
    assign push   = s_valid_i && s_ready_o;

    // Stream side and status are built from registered state only.
    assign s_ready_o = rdy_en_q && !full && !wat_q;
    assign status_o  = WIDTH'({4'b0000, udr_q, ovf_q, full, empty});
    assign ctrl_o    = {1'b0, ctrl_q};
    assign dat_o     = dat_q;
    assign wat_o     = wat_q;
    assign rty_o     = 1'b0;
    // Dropping cyc_i in the response cycle masks the termination.
    assign ack_o     = ack_q && cyc_i;

`ifdef SPI_REG_BANK_ERR_EN
    logic err_q, err_d;
    logic mapped;
    assign mapped = (adr_i <= A_SCR3);
    assign err_o  = err_q && cyc_i;
`else
    assign err_o  = 1'b0;
`endif

    // Next-state: bus decode, register writes, read mux, sticky flags, FIFO pointers.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        ovf_d     = ovf_q;
        udr_d     = udr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        dat_d     = '0;
        wat_d     = flush;
        rdy_en_d  = 1'b1;
`ifdef SPI_REG_BANK_ERR_EN
        err_d     = 1'b0;
`endif

        if (acc) begin
`ifdef SPI_REG_BANK_ERR_EN
            ack_d = mapped;
            err_d = !mapped;
`else
            ack_d = 1'b1;
`endif
            if (!we_i) begin
                case (adr_i)
                    A_STREAM: dat_d = empty ? '0 : mem_q[rd_ptr_q];
                    A_FILL:   dat_d = WIDTH'(cnt_q);
                    A_CTRL:   dat_d = {1'b0, ctrl_q};
                    A_STATUS: dat_d = status_o;
                    A_SCR0, A_SCR1, A_SCR2, A_SCR3: dat_d = scratch_q[adr_i[1:0]];
                    default:  dat_d = '0;
                endcase
            end else begin
                case (adr_i)
                    A_CTRL: ctrl_d = dat_i[6:0];
                    A_SCR0, A_SCR1, A_SCR2, A_SCR3: scratch_d[adr_i[1:0]] = dat_i;
                    default: ;
                endcase
            end
        end

        // Sticky flags: clear first, then set, so a same-cycle set wins.
        if (wr_acc && (adr_i == A_STATUS)) begin
            if (dat_i[2]) ovf_d = 1'b0;
            if (dat_i[3]) udr_d = 1'b0;
        end
        if (s_valid_i && full) ovf_d = 1'b1;
        if (rd_acc && (adr_i == A_STREAM) && empty) udr_d = 1'b1;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      cnt_d = cnt_q + CW'(1);
            else if (!push && pop) cnt_d = cnt_q - CW'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_i) begin
            ctrl_q    <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            udr_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            wat_q     <= 1'b0;
            rdy_en_q  <= 1'b0;
`ifdef SPI_REG_BANK_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            ovf_q     <= ovf_d;
            udr_q     <= udr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            wat_q     <= wat_d;
            rdy_en_q  <= rdy_en_d;
`ifdef SPI_REG_BANK_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; the occupancy counter alone defines validity.
        if (push) mem_q[wr_ptr_q] <= s_data_i;
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed self-checking bench for spi_reg_bank.
// Build with +define+SPI_REG_BANK_ERR_EN to check the error-termination variant.

module tb_spi_reg_bank;

`ifdef SPI_REG_BANK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       cyc_i = 1'b0;
    logic       stb_i = 1'b0;
    logic       we_i  = 1'b0;
    logic [6:0] adr_i = '0;
    logic [7:0] dat_i = '0;
    logic [7:0] dat_o;
    logic       ack_o, wat_o, rty_o, err_o;
    logic       s_valid_i = 1'b0;
    logic       s_ready_o;
    logic [7:0] s_data_i = '0;
    logic [7:0] ctrl_o, status_o;

    int checks = 0;
    int errors = 0;

    logic       ack, err;
    logic [7:0] q;

    spi_reg_bank dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .wat_o(wat_o),
        .rty_o(rty_o), .err_o(err_o), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .s_data_i(s_data_i), .ctrl_o(ctrl_o), .status_o(status_o)
    );

    always #5 clk_i = ~clk_i;

    // One accepted request; returns the response sampled 1 ns after the accept edge.
    task automatic wb(input logic w, input logic [6:0] a, input logic [7:0] d,
                      output logic r_ack, output logic r_err, output logic [7:0] r_dat);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
        @(posedge clk_i); #1;
        r_ack = ack_o; r_err = err_o; r_dat = dat_o;
        stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        s_valid_i = 1'b1; s_data_i = b;
        @(posedge clk_i); #1;
        s_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (ack_o !== 1'b0 || err_o !== 1'b0 || wat_o !== 1'b0 || rty_o !== 1'b0 || dat_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: ack=%b err=%b wat=%b rty=%b dat=%h, expected 0 0 0 0 00",
                     ack_o, err_o, wat_o, rty_o, dat_o);
        end
        checks++;
        if (ctrl_o !== 8'h00 || status_o !== 8'h01 || s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: ctrl=%h status=%h ready=%b, expected 00 01 0", ctrl_o, status_o, s_ready_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: ready=%b, expected 1", s_ready_o);
        end
        wb(1'b0, 7'h03, 8'h00, ack, err, q);
        checks++;
        if (ack !== 1'b1 || q !== 8'h01) begin
            errors++;
            $display("FAIL reset_rd_status: ack=%b dat=%h, expected ack=1 dat=01", ack, q);
        end
        wb(1'b0, 7'h02, 8'h00, ack, err, q);
        checks++;
        if (ack !== 1'b1 || q !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_ctrl: ack=%b dat=%h, expected ack=1 dat=00", ack, q);
        end
    endtask

    task automatic test_stream;
        logic [7:0] exp_d [4];
        logic [6:0] adrs  [4];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h00;
        adrs[0] = 7'h00; adrs[1] = 7'h00; adrs[2] = 7'h00; adrs[3] = 7'h01;
        push(8'h11); push(8'h22); push(8'h33);
        checks++;
        if (status_o !== 8'h00) begin
            errors++;
            $display("FAIL stream_status_loaded: status=%h, expected 00", status_o);
        end
        for (int i = 0; i < 4; i++) begin
            wb(1'b0, adrs[i], 8'h00, ack, err, q);
            checks++;
            if (ack !== 1'b1 || q !== exp_d[i]) begin
                errors++;
                $display("FAIL stream_b2b_%0d: ack=%b dat=%h, expected ack=1 dat=%h", i, ack, q, exp_d[i]);
            end
        end
        checks++;
        if (status_o !== 8'h01) begin
            errors++;
            $display("FAIL stream_status_drained: status=%h, expected 01", status_o);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
        checks++;
        if (s_ready_o !== 1'b0 || status_o !== 8'h06) begin
            errors++;
            $display("FAIL ovf_full: ready=%b status=%h, expected 0 06", s_ready_o, status_o);
        end
        wb(1'b0, 7'h01, 8'h00, ack, err, q);
        checks++;
        if (ack !== 1'b1 || q !== 8'd16) begin
            errors++;
            $display("FAIL ovf_fill: ack=%b dat=%h, expected ack=1 dat=10", ack, q);
        end
        wb(1'b1, 7'h03, 8'h04, ack, err, q);
        checks++;
        if (ack !== 1'b1 || status_o !== 8'h02) begin
            errors++;
            $display("FAIL ovf_w1c: ack=%b status=%h, expected ack=1 status=02", ack, status_o);
        end
        wb(1'b1, 7'h02, 8'h80, ack, err, q);
        @(posedge clk_i); #1;
        checks++;
        if (status_o !== 8'h01 || ctrl_o !== 8'h00 || s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flushed: status=%h ctrl=%h ready=%b, expected 01 00 1", status_o, ctrl_o, s_ready_o);
        end
    endtask

    task automatic test_underrun;
        wb(1'b0, 7'h00, 8'h00, ack, err, q);
        checks++;
        if (ack !== 1'b1 || q !== 8'h00 || status_o !== 8'h09) begin
            errors++;
            $display("FAIL udr_read: ack=%b dat=%h status=%h, expected 1 00 09", ack, q, status_o);
        end
        push(8'h5A);
        // Push 0x6B and pop 0x5A on the same edge.
        s_valid_i = 1'b1; s_data_i = 8'h6B;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 7'h00;
        @(posedge clk_i); #1;
        s_valid_i = 1'b0; stb_i = 1'b0;
        checks++;
        if (ack_o !== 1'b1 || dat_o !== 8'h5A) begin
            errors++;
            $display("FAIL udr_push_pop: ack=%b dat=%h, expected ack=1 dat=5a", ack_o, dat_o);
        end
        wb(1'b0, 7'h01, 8'h00, ack, err, q);
        checks++;
        if (q !== 8'h01) begin
            errors++;
            $display("FAIL udr_fill_same: dat=%h, expected 01", q);
        end
        wb(1'b0, 7'h00, 8'h00, ack, err, q);
        checks++;
        if (q !== 8'h6B) begin
            errors++;
            $display("FAIL udr_second_pop: dat=%h, expected 6b", q);
        end
        wb(1'b1, 7'h03, 8'h08, ack, err, q);
        checks++;
        if (status_o !== 8'h01) begin
            errors++;
            $display("FAIL udr_w1c: status=%h, expected 01", status_o);
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        wb(1'b0, 7'h01, 8'h00, ack, err, q);
        checks++;
        if (q !== 8'h05) begin
            errors++;
            $display("FAIL flush_pre_fill: dat=%h, expected 05", q);
        end
        wb(1'b1, 7'h02, 8'h85, ack, err, q);
        checks++;
        if (ack !== 1'b1 || wat_o !== 1'b1 || s_ready_o !== 1'b0 || ctrl_o !== 8'h05 || status_o !== 8'h01) begin
            errors++;
            $display("FAIL flush_wat_cycle: ack=%b wat=%b ready=%b ctrl=%h status=%h, expected 1 1 0 05 01",
                     ack, wat_o, s_ready_o, ctrl_o, status_o);
        end
        // A request presented in the stall cycle must wait one cycle.
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 7'h01;
        @(posedge clk_i); #1;
        checks++;
        if (ack_o !== 1'b0 || wat_o !== 1'b0 || s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_stalled: ack=%b wat=%b ready=%b, expected 0 0 1", ack_o, wat_o, s_ready_o);
        end
        @(posedge clk_i); #1;
        stb_i = 1'b0;
        checks++;
        if (ack_o !== 1'b1 || dat_o !== 8'h00) begin
            errors++;
            $display("FAIL flush_fill: ack=%b dat=%h, expected ack=1 dat=00", ack_o, dat_o);
        end
        wb(1'b0, 7'h02, 8'h00, ack, err, q);
        checks++;
        if (q !== 8'h05) begin
            errors++;
            $display("FAIL flush_ctrl_rd: dat=%h, expected 05", q);
        end
    endtask

    task automatic test_scratch;
        logic [7:0] vals [4];
        vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3; vals[3] = 8'hD4;
        for (int i = 0; i < 4; i++) wb(1'b1, 7'h04 + 7'(i), vals[i], ack, err, q);
        for (int i = 0; i < 4; i++) begin
            wb(1'b0, 7'h04 + 7'(i), 8'h00, ack, err, q);
            checks++;
            if (ack !== 1'b1 || q !== vals[i]) begin
                errors++;
                $display("FAIL scratch_%0d: ack=%b dat=%h, expected ack=1 dat=%h", i, ack, q, vals[i]);
            end
        end
        wb(1'b1, 7'h01, 8'hFF, ack, err, q);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL ro_write_ack: ack=%b, expected 1", ack);
        end
        wb(1'b0, 7'h01, 8'h00, ack, err, q);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL ro_write_noeffect: dat=%h, expected 00", q);
        end
    endtask

    task automatic test_unmapped;
        logic [6:0] adrs [2];
        adrs[0] = 7'h7F; adrs[1] = 7'h08;
        for (int i = 0; i < 2; i++) begin
            wb(1'b0, adrs[i], 8'h00, ack, err, q);
            checks++;
            if (ack !== !ERR_EN || err !== ERR_EN || q !== 8'h00) begin
                errors++;
                $display("FAIL unmapped_rd_%h: ack=%b err=%b dat=%h, expected ack=%b err=%b dat=00",
                         adrs[i], ack, err, q, !ERR_EN, ERR_EN);
            end
            wb(1'b1, adrs[i], 8'hFF, ack, err, q);
            checks++;
            if (ack !== !ERR_EN || err !== ERR_EN) begin
                errors++;
                $display("FAIL unmapped_wr_%h: ack=%b err=%b, expected ack=%b err=%b",
                         adrs[i], ack, err, !ERR_EN, ERR_EN);
            end
        end
        wb(1'b0, 7'h04, 8'h00, ack, err, q);
        checks++;
        if (q !== 8'hA1 || ctrl_o !== 8'h05 || status_o !== 8'h01) begin
            errors++;
            $display("FAIL unmapped_noeffect: scr0=%h ctrl=%h status=%h, expected a1 05 01", q, ctrl_o, status_o);
        end
    endtask

    task automatic test_cyc_drop;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 7'h04; dat_i = 8'h3C;
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        #1;
        checks++;
        if (ack_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL cyc_drop_wr: ack=%b err=%b, expected 0 0", ack_o, err_o);
        end
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; adr_i = 7'h7F;
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0;
        #1;
        checks++;
        if (ack_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL cyc_drop_unmapped: ack=%b err=%b, expected 0 0", ack_o, err_o);
        end
        @(posedge clk_i); #1;
        wb(1'b0, 7'h04, 8'h00, ack, err, q);
        checks++;
        if (ack !== 1'b1 || q !== 8'h3C) begin
            errors++;
            $display("FAIL cyc_drop_sidefx: ack=%b dat=%h, expected ack=1 dat=3c", ack, q);
        end
    endtask

    task automatic test_reset_mid;
        push(8'h01); push(8'h02); push(8'h03);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 7'h00;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        stb_i = 1'b0;
        checks++;
        if (ack_o !== 1'b0 || dat_o !== 8'h00 || status_o !== 8'h01 || ctrl_o !== 8'h00 || s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ack=%b dat=%h status=%h ctrl=%h ready=%b, expected 0 00 01 00 0",
                     ack_o, dat_o, status_o, ctrl_o, s_ready_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        wb(1'b0, 7'h01, 8'h00, ack, err, q);
        checks++;
        if (ack !== 1'b1 || q !== 8'h00 || s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_fill: ack=%b dat=%h ready=%b, expected 1 00 1", ack, q, s_ready_o);
        end
        wb(1'b0, 7'h04, 8'h00, ack, err, q);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_scratch: dat=%h, expected 00", q);
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_overflow;
        test_underrun;
        test_flush;
        test_scratch;
        test_unmapped;
        test_cyc_drop;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
